// File: rtl/alu_sched_if.sv
// rtl/alu_sched_if.sv - request/response channel bundle for the alu_sched round-robin scheduler
//
// Signals:
//   req0_*/req1_*  valid, ready, op[1:0], operand[3:0] (+ lock with ALU_SCHED_LOCK_EN)
//   rsp_*          valid, ready, id, data[3:0]
// Modports:
//   master  requester/consumer side (drives requests, rsp_ready)
//   slave   scheduler side (drives readies and the response)
// Macro: ALU_SCHED_LOCK_EN adds req0_lock/req1_lock.

interface alu_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [1:0] req0_op;
    logic [3:0] req0_operand;
    logic       req1_valid;
    logic       req1_ready;
    logic [1:0] req1_op;
    logic [3:0] req1_operand;
`ifdef ALU_SCHED_LOCK_EN
    logic       req0_lock;
    logic       req1_lock;
`endif
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [3:0] rsp_data;

`ifdef ALU_SCHED_LOCK_EN
    modport master (
        output req0_valid, req0_op, req0_operand, req0_lock,
        output req1_valid, req1_op, req1_operand, req1_lock,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );
    modport slave (
        input  req0_valid, req0_op, req0_operand, req0_lock,
        input  req1_valid, req1_op, req1_operand, req1_lock,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );
`else
    modport master (
        output req0_valid, req0_op, req0_operand,
        output req1_valid, req1_op, req1_operand,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready
    );
    modport slave (
        input  req0_valid, req0_op, req0_operand,
        input  req1_valid, req1_op, req1_operand,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready
    );
`endif
endinterface

// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - round-robin scheduler sharing one 4-bit accumulator ALU between two requesters
//
// Ports:
//   clock, reset_L     clock; asynchronous active-low reset
//   bus (slave)        request channels 0/1 and the single response channel
//   alu_op[1:0]        to ALU op (2'b10 with operand 0 = hold when idle)
//   alu_operand[3:0]   to ALU operand
//   alu_result[3:0]    from ALU registered accumulator, passed through as rsp_data
// Parameter:
//   LOCK_MAX           max consecutive locked grants (only with ALU_SCHED_LOCK_EN)
// Macro: ALU_SCHED_LOCK_EN enables the per-requester lock feature.

module alu_sched #(
    parameter int LOCK_MAX = 4
) (
    input  logic        clock,
    input  logic        reset_L,
    alu_sched_if.slave  bus,
    output logic [1:0]  alu_op,
    output logic [3:0]  alu_operand,
    input  logic [3:0]  alu_result
);

    localparam logic [1:0] OP_OR = 2'b10;

    if (LOCK_MAX < 1) begin : g_bad_lock_max
        $error("alu_sched: LOCK_MAX must be at least 1");
    end

    logic rsp_valid_q;
    logic rsp_id_q;
    logic last_grant;   // 1 = req1 granted last, so req0 wins the next tie
    logic can_issue;
    logic grant0;
    logic grant1;
    logic xfer_any;

    // Gating with reset_L keeps readies low while reset is held.
    assign can_issue = reset_L && (!rsp_valid_q || bus.rsp_ready);

`ifdef ALU_SCHED_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    logic             lock_active;
    logic             lock_owner;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             lock_hold;
    logic             xfer_lock;
    logic             owner_valid;

    assign owner_valid = lock_owner ? bus.req1_valid : bus.req0_valid;
    // Dropping valid releases the lock in the same cycle, so arbitration falls through.
    assign lock_hold   = lock_active && owner_valid;
    assign xfer_lock   = grant1 ? bus.req1_lock : bus.req0_lock;

    always_comb begin
        cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        if (lock_active && (lock_owner == grant1)) begin
            cnt_next = lock_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_issue) begin
`ifdef ALU_SCHED_LOCK_EN
            if (lock_hold) begin
                grant0 = !lock_owner;
                grant1 = lock_owner;
            end else
`endif
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    // Grants are only raised for valid requesters, so a grant is a transfer.
    assign xfer_any       = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_comb begin
        alu_op      = OP_OR;
        alu_operand = 4'h0;
        if (grant0) begin
            alu_op      = bus.req0_op;
            alu_operand = bus.req0_operand;
        end else if (grant1) begin
            alu_op      = bus.req1_op;
            alu_operand = bus.req1_operand;
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            last_grant  <= 1'b1;
        end else if (xfer_any) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= grant1;
            last_grant  <= grant1;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef ALU_SCHED_LOCK_EN
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            lock_active <= 1'b0;
            lock_owner  <= 1'b0;
            lock_cnt    <= '0;
        end else if (xfer_any) begin
            // Hitting LOCK_MAX releases right away; last_grant then hands the tie to the other side.
            if (xfer_lock && (int'(cnt_next) < LOCK_MAX)) begin
                lock_active <= 1'b1;
                lock_owner  <= grant1;
                lock_cnt    <= cnt_next;
            end else begin
                lock_active <= 1'b0;
                lock_cnt    <= '0;
            end
        end else if (lock_active && !owner_valid) begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
        end
    end
`endif

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = alu_result;

endmodule
